vram_raster_addr_gen: RTL
=========================

Name: vram_raster_addr_gen

Overview:
Parametrised raster-scan VRAM address generator. It walks an active window of W x H pixels and emits one byte address per pixel: addr = base + y*LINE_STRIDE + x*BYTES_PER_PIXEL. The address is built incrementally, with no multiplier. Output uses a valid/ready handshake toward the VRAM access arbiter. The block supports single-frame and continuous modes, abort, and address-space wrap. It replaces free-running x/y counters feeding a combinational multiply.

Parameters:
ADDR_WIDTH, 18, VRAM byte-address width; all address arithmetic is modulo 2^ADDR_WIDTH.
X_WIDTH, 9, width of the pixel-column counter and of active_width.
Y_WIDTH, 10, width of the line counter and of active_height.
LINE_STRIDE, 720, bytes between starts of consecutive lines.
BYTES_PER_PIXEL, 2, address increment per pixel; must be 1, 2 or 4.

Ports:
clk  input  1  system clock; all logic on rising edge.
reset_n  input  1  synchronous active-low reset.
start  input  1  pulse; begins a frame when IDLE or DONE.
abort  input  1  pulse; terminates the scan.
continuous  input  1  sampled at start; 1 = restart the frame automatically after the last pixel.
base_addr  input  ADDR_WIDTH  frame base byte address; sampled at start.
active_width  input  X_WIDTH  pixels per line; sampled at start.
active_height  input  Y_WIDTH  lines per frame; sampled at start.
addr_out  output  ADDR_WIDTH  current pixel byte address.
x_out  output  X_WIDTH  current column.
y_out  output  Y_WIDTH  current line.
addr_valid  output  1  addr_out/x_out/y_out are valid.
addr_ready  input  1  consumer accepts the beat when addr_valid & addr_ready.
line_end  output  1  qualifies the current beat as the last pixel of a line.
frame_end  output  1  qualifies the current beat as the last pixel of the frame.
busy  output  1  high in RUN.
done  output  1  one-cycle pulse on completion of a non-continuous frame.

Behaviour:
- Reset (reset_n=0 at a clock edge): state=IDLE. addr_out=0, x_out=0, y_out=0, addr_valid=0, line_end=0, frame_end=0, busy=0, done=0. Reset wins over every other input, including mid-frame; an in-flight beat is dropped.
- FSM states: IDLE, RUN, DONE.
- IDLE/DONE, start=1:
  - Latch base_addr, active_width, active_height and continuous.
  - If active_width==0 or active_height==0: go to DONE and pulse done on the next cycle. No beat is emitted.
  - Otherwise: go to RUN. The next cycle has addr_valid=1, addr_out=base_addr, x=0, y=0. Latency from start to first valid beat is 1 cycle.
- RUN:
  - addr_valid stays 1.
  - Outputs hold stable while addr_ready=0; there is no combinational path from addr_ready to the outputs.
  - Each accepted beat advances the position:
    - Within a line: x+1, addr += BYTES_PER_PIXEL.
    - At x==W-1, next line: x=0, y+1, line_base += LINE_STRIDE, addr = new line_base.
    - At x==W-1 and y==H-1: the frame is complete (see below).
  - Throughput: one beat per cycle while addr_ready=1.
- line_end = addr_valid & (x==W-1). frame_end = line_end & (y==H-1). Both are registered and aligned with the beat.
- Frame completion on the accepted frame_end beat:
  - continuous=1: the next cycle presents base_addr again with x=0, y=0. No bubble; the latched config is reused.
  - continuous=0: go to DONE with addr_valid=0 and done=1 for exactly 1 cycle; busy drops in the same cycle.
- DONE behaves as IDLE, except it is where done pulses. start in RUN is ignored.
- abort=1 in RUN: next cycle state=IDLE, addr_valid=0, busy=0, no done pulse. A beat accepted in the same cycle as abort is counted as transferred. abort and start in the same cycle in IDLE/DONE: abort wins and the state stays idle.
- Arithmetic: addr and line_base are ADDR_WIDTH registers and wrap silently modulo 2^ADDR_WIDTH. x and y never exceed W-1 and H-1.
- Continuous-mode changes to base/size take effect only on a new start after abort, or after a non-continuous completion.

Test Plan:
1. Basic frame: base=0, W=360, H=2, continuous=0, addr_ready=1, start. The bench must see exactly these beats, in order:
   - 0,2,...,718 with line_end on 718.
   - 720,722,...,1438 with frame_end on 1438.
   - done pulses 1 cycle after 1438; exactly 720 beats total.
2. Backpressure: same config, ready toggling pseudo-randomly. The address sequence is identical to scenario 1, and outputs hold stable during every ready=0 cycle.
3. Wrap: base=18'h3FFFC, W=4, H=1. Beats are 3FFFC, 3FFFE, 00000, 00002; frame_end on 00002.
4. Degenerate and continuous cases:
   - W=0, H=5, start: no addr_valid ever; done pulses the cycle after start.
   - continuous=1, W=2, H=2, base=100: beats 100,102,820,822,100,... repeating with no gap.
5. Abort and reset mid-frame:
   - abort at beat 10 of scenario 1: addr_valid=0 next cycle, no done. A new start restarts at base.
   - reset_n=0 mid-frame: all outputs at reset values on the next edge.
6. start while busy: a start pulse during RUN has no effect; the sequence continues unchanged.

Source files
------------

// File: rtl/vram_raster_addr_gen.sv
// Raster-scan VRAM address generator: walks a W x H window and emits one byte
// address per pixel over a valid/ready handshake, built incrementally without a multiplier.
module vram_raster_addr_gen #(
    parameter int ADDR_WIDTH      = 18,
    parameter int X_WIDTH         = 9,
    parameter int Y_WIDTH         = 10,
    parameter int LINE_STRIDE     = 720,
    parameter int BYTES_PER_PIXEL = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic                  abort,
    input  logic                  continuous,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [X_WIDTH-1:0]    active_width,
    input  logic [Y_WIDTH-1:0]    active_height,
    output logic [ADDR_WIDTH-1:0] addr_out,
    output logic [X_WIDTH-1:0]    x_out,
    output logic [Y_WIDTH-1:0]    y_out,
    output logic                  addr_valid,
    input  logic                  addr_ready,
    output logic                  line_end,
    output logic                  frame_end,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] STRIDE   = ADDR_WIDTH'(LINE_STRIDE);
    localparam logic [ADDR_WIDTH-1:0] PIX_STEP = ADDR_WIDTH'(BYTES_PER_PIXEL);

    state_t                  state;
    logic [ADDR_WIDTH-1:0]   base_q;
    logic [ADDR_WIDTH-1:0]   line_base;
    logic [X_WIDTH-1:0]      width_q;
    logic [Y_WIDTH-1:0]      height_q;
    logic                    cont_q;

    logic [X_WIDTH-1:0]      x_inc;
    logic [Y_WIDTH-1:0]      y_inc;
    logic [X_WIDTH-1:0]      x_last;
    logic [Y_WIDTH-1:0]      y_last;
    logic [ADDR_WIDTH-1:0]   next_line_base;
    logic                    frame_one_wide;
    logic                    frame_one_px;

    // NOTE: every signal driven here gets a value on every path, so no latch is inferred.
    always_comb begin
        x_inc          = x_out + X_WIDTH'(1);
        y_inc          = y_out + Y_WIDTH'(1);
        x_last         = width_q - X_WIDTH'(1);
        y_last         = height_q - Y_WIDTH'(1);
        next_line_base = line_base + STRIDE;
        frame_one_wide = (width_q == X_WIDTH'(1));
        frame_one_px   = frame_one_wide && (height_q == Y_WIDTH'(1));
    end

    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= IDLE;
            base_q     <= '0;
            line_base  <= '0;
            width_q    <= '0;
            height_q   <= '0;
            cont_q     <= 1'b0;
            addr_out   <= '0;
            x_out      <= '0;
            y_out      <= '0;
            addr_valid <= 1'b0;
            line_end   <= 1'b0;
            frame_end  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start && !abort) begin
                        base_q   <= base_addr;
                        width_q  <= active_width;
                        height_q <= active_height;
                        cont_q   <= continuous;
                        if (active_width == '0 || active_height == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state      <= RUN;
                            busy       <= 1'b1;
                            addr_valid <= 1'b1;
                            addr_out   <= base_addr;
                            line_base  <= base_addr;
                            x_out      <= '0;
                            y_out      <= '0;
                            line_end   <= (active_width == X_WIDTH'(1));
                            frame_end  <= (active_width == X_WIDTH'(1)) &&
                                          (active_height == Y_WIDTH'(1));
                        end
                    end
                end

                RUN: begin
                    if (abort) begin
                        state      <= IDLE;
                        busy       <= 1'b0;
                        addr_valid <= 1'b0;
                        line_end   <= 1'b0;
                        frame_end  <= 1'b0;
                    end else if (addr_ready) begin
                        if (frame_end) begin
                            if (cont_q) begin
                                // Seamless restart reuses the configuration latched at start.
                                addr_out  <= base_q;
                                line_base <= base_q;
                                x_out     <= '0;
                                y_out     <= '0;
                                line_end  <= frame_one_wide;
                                frame_end <= frame_one_px;
                            end else begin
                                state      <= DONE;
                                busy       <= 1'b0;
                                addr_valid <= 1'b0;
                                line_end   <= 1'b0;
                                frame_end  <= 1'b0;
                                done       <= 1'b1;
                            end
                        end else if (line_end) begin
                            x_out     <= '0;
                            y_out     <= y_inc;
                            line_base <= next_line_base;
                            addr_out  <= next_line_base;
                            line_end  <= frame_one_wide;
                            frame_end <= frame_one_wide && (y_inc == y_last);
                        end else begin
                            x_out     <= x_inc;
                            addr_out  <= addr_out + PIX_STEP;
                            line_end  <= (x_inc == x_last);
                            frame_end <= (x_inc == x_last) && (y_out == y_last);
                        end
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule
